data_mem_ctrl: RTL

DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

---
 rtl/data_mem_if.sv | 23 ++
 rtl/data_mem_ctrl.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/data_mem_if.sv
// Request/response bundle between the control unit and the data memory.
// The requester holds READ/WRITE and the operands while BUSYWAIT is high.
interface data_mem_if;
    logic        READ;
    logic        WRITE;
    logic [31:0] ADDRESS;
    logic [31:0] WRITEDATA;
    logic [2:0]  LOADSIGNAL;
    logic [1:0]  STORESIGNAL;
    logic [31:0] READDATA;
    logic        BUSYWAIT;
    logic        ERROR;

    modport master (
        output READ, WRITE, ADDRESS, WRITEDATA, LOADSIGNAL, STORESIGNAL,
        input  READDATA, BUSYWAIT, ERROR
    );

    modport slave (
        input  READ, WRITE, ADDRESS, WRITEDATA, LOADSIGNAL, STORESIGNAL,
        output READDATA, BUSYWAIT, ERROR
    );
endinterface

// File: rtl/data_mem_ctrl.sv
// Fixed-latency data memory with byte/half/word loads and stores,
// misalignment detection and an IDLE/ACCESS/DONE request FSM.
module data_mem_ctrl #(
    parameter int MEM_WORDS = 256,
    parameter int LATENCY   = 4
) (
    input logic       CLK,
    input logic       RESET,
    data_mem_if.slave bus
);
    localparam int AW = $clog2(MEM_WORDS);
    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_e;

    state_e        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [AW+1:0] addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [2:0]    ld_q, ld_d;
    logic [1:0]    st_q, st_d;
    logic          wr_q, wr_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          err_q, err_d;

    logic [31:0]   mem_q [MEM_WORDS];

    logic          accept, finish, mis, mem_we;
    logic          lb, lh, lbu, lhu, lw;
    logic [AW-1:0] widx;
    logic [31:0]   word, shifted, load_val, wmask, wbits;
    logic [15:0]   half;
    logic [7:0]    byte_v;

    assign accept = state_q == IDLE && (bus.READ || bus.WRITE);
    assign finish = state_q == ACCESS && cnt_q == 4'd0;

    // State register
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = ACCESS;
                    cnt_d   = CNT_INIT;
                end
            end
            ACCESS: begin
                if (cnt_q == 4'd0) state_d = DONE;
                else cnt_d = cnt_q - 4'd1;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        bus.BUSYWAIT = RESET &&
            ((state_q == IDLE && (bus.READ || bus.WRITE)) || state_q == ACCESS);
        mem_we = RESET && finish && wr_q && !mis && st_q != 2'd0;
    end

    assign bus.READDATA = rdata_q;
    assign bus.ERROR    = err_q;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            addr_q  <= '0;
            wdata_q <= '0;
            ld_q    <= '0;
            st_q    <= '0;
            wr_q    <= 1'b0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            ld_q    <= ld_d;
            st_q    <= st_d;
            wr_q    <= wr_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        addr_d  = addr_q;
        wdata_d = wdata_q;
        ld_d    = ld_q;
        st_d    = st_q;
        wr_d    = wr_q;
        rdata_d = rdata_q;
        err_d   = 1'b0;
        if (accept) begin
            addr_d  = bus.ADDRESS[AW+1:0];
            wdata_d = bus.WRITEDATA;
            ld_d    = bus.LOADSIGNAL;
            st_d    = bus.STORESIGNAL;
            wr_d    = bus.WRITE;
        end
        if (finish) begin
            err_d = mis;
            if (!wr_q) rdata_d = mis ? 32'd0 : load_val;
        end
    end

    // Unknown load codes fall through to a full-word load
    always_comb begin
        lb  = ld_q == 3'd1;
        lh  = ld_q == 3'd2;
        lbu = ld_q == 3'd4;
        lhu = ld_q == 3'd5;
        lw  = !(lb || lh || lbu || lhu);
        if (wr_q)
            mis = (st_q == 2'd2 && addr_q[0]) ||
                  (st_q == 2'd3 && addr_q[1:0] != 2'd0);
        else
            mis = ((lh || lhu) && addr_q[0]) ||
                  (lw && addr_q[1:0] != 2'd0);
    end

    assign widx    = addr_q[AW+1:2];
    assign word    = mem_q[widx];
    assign shifted = word >> {addr_q[1:0], 3'b000};
    assign byte_v  = shifted[7:0];
    assign half    = addr_q[1] ? word[31:16] : word[15:0];

    always_comb begin
        unique case (1'b1)
            lb:      load_val = {{24{byte_v[7]}}, byte_v};
            lbu:     load_val = {24'd0, byte_v};
            lh:      load_val = {{16{half[15]}}, half};
            lhu:     load_val = {16'd0, half};
            default: load_val = word;
        endcase
    end

    always_comb begin
        wmask = 32'd0;
        wbits = 32'd0;
        unique case (st_q)
            2'd1: begin
                wmask = 32'h0000_00FF << {addr_q[1:0], 3'b000};
                wbits = {4{wdata_q[7:0]}};
            end
            2'd2: begin
                wmask = addr_q[1] ? 32'hFFFF_0000 : 32'h0000_FFFF;
                wbits = {2{wdata_q[15:0]}};
            end
            2'd3: begin
                wmask = 32'hFFFF_FFFF;
                wbits = wdata_q;
            end
            default: begin
                wmask = 32'd0;
                wbits = 32'd0;
            end
        endcase
    end

    // Storage is never reset so contents survive RESET
    always_ff @(posedge CLK) begin
        if (mem_we) mem_q[widx] <= (word & ~wmask) | (wbits & wmask);
    end
endmodule
